inta_sequencer: RTL and testbench

CPU-side interrupt acknowledge initiator for the 8259 PIC subsystem. It watches the PIC's INT line and runs the two-pulse INTA handshake on `inta_n`. It captures the vector the PIC drives on the data bus during the second pulse and hands it to the CPU model over a valid/ready handshake. Unless automatic EOI is configured, it then writes a non-specific EOI (OCW2) back to the PIC once the CPU signals that service is complete.

---
 rtl/pic_pkg.sv | 23 ++
 rtl/inta_sequencer_if.sv | 33 +++
 rtl/inta_sequencer_cycle_timer.sv | 42 ++++
 rtl/inta_sequencer.sv | 149 ++++++++++++++
 tb/tb_inta_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pic_pkg: shared types and constants for the 8259 INTA sequencer      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package pic_pkg;

  localparam int         TIMER_W          = 4;
  localparam logic [7:0] OCW2_NONSPEC_EOI = 8'h20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INTA1    = 3'd1,
    GAP      = 3'd2,
    INTA2    = 3'd3,
    DELIVER  = 3'd4,
    WAIT_SVC = 3'd5,
    EOI_WR   = 3'd6,
    EOI_HOLD = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/inta_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inta_sequencer_if: PIC/CPU-side signal bundle for inta_sequencer     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface inta_sequencer_if;

  logic       int_req;
  logic       int_enable;
  logic [7:0] data_in;
  logic       vec_ready;
  logic       svc_done;
  logic       inta_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       busy;

  modport master (
    input  int_req, int_enable, data_in, vec_ready, svc_done,
    output inta_n, wr_n, a0, data_out, data_oe, vector_out, vector_valid, busy
  );

  modport slave (
    output int_req, int_enable, data_in, vec_ready, svc_done,
    input  inta_n, wr_n, a0, data_out, data_oe, vector_out, vector_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/inta_sequencer_cycle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cycle_timer: loadable saturating down-counter with a zero flag       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module cycle_timer
  import pic_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Holds at zero so an idle timer can never wrap.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/inta_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inta_sequencer: two-pulse INTA handshake, vector delivery, EOI write |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int WR_LOW_CYCLES   = 2,
  parameter bit AUTO_EOI        = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  inta_sequencer_if.master   bus
);

  localparam logic [TIMER_W-1:0] c_low_load = TIMER_W'(INTA_LOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_gap_load = TIMER_W'(INTA_GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_wr_load  = TIMER_W'(WR_LOW_CYCLES - 1);

  state_t             state_q, state_d;
  logic               go_q, go_d;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_zero;

  logic       inta_n_q, inta_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a0_q, a0_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic [7:0] vector_out_q, vector_out_d;
  logic       vector_valid_q, vector_valid_d;
  logic       busy_q, busy_d;

  cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // go_q is a one-cycle sample of the trigger (int_req&&int_enable in IDLE,
  // svc_done in WAIT_SVC); the state acts on it at the following edge.
  always_comb begin
    state_d      = state_q;
    go_d         = 1'b0;
    timer_load   = 1'b0;
    timer_val    = '0;
    vector_out_d = vector_out_q;
    case (state_q)
      IDLE: begin
        if (go_q) begin
          state_d    = INTA1;
          timer_load = 1'b1;
          timer_val  = c_low_load;
        end else begin
          go_d = bus.int_req && bus.int_enable;
        end
      end
      INTA1: if (timer_zero) begin
        state_d    = GAP;
        timer_load = 1'b1;
        timer_val  = c_gap_load;
      end
      GAP: if (timer_zero) begin
        state_d    = INTA2;
        timer_load = 1'b1;
        timer_val  = c_low_load;
      end
      INTA2: if (timer_zero) begin
        state_d      = DELIVER;
        vector_out_d = bus.data_in;
      end
      DELIVER: if (bus.vec_ready) begin
        state_d = WAIT_SVC;
      end
      WAIT_SVC: begin
        if (go_q) begin
          if (AUTO_EOI) begin
            state_d = IDLE;
          end else begin
            state_d    = EOI_WR;
            timer_load = 1'b1;
            timer_val  = c_wr_load;
          end
        end else begin
          go_d = bus.svc_done;
        end
      end
      EOI_WR: if (timer_zero) begin
        state_d = EOI_HOLD;
      end
      EOI_HOLD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    inta_n_d       = !((state_d == INTA1) || (state_d == INTA2));
    wr_n_d         = (state_d != EOI_WR);
    a0_d           = 1'b0;
    data_oe_d      = (state_d == EOI_WR) || (state_d == EOI_HOLD);
    data_out_d     = data_oe_d ? OCW2_NONSPEC_EOI : 8'h00;
    vector_valid_d = (state_d == DELIVER);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      go_q           <= 1'b0;
      inta_n_q       <= 1'b1;
      wr_n_q         <= 1'b1;
      a0_q           <= 1'b0;
      data_out_q     <= 8'h00;
      data_oe_q      <= 1'b0;
      vector_out_q   <= 8'h00;
      vector_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      go_q           <= go_d;
      inta_n_q       <= inta_n_d;
      wr_n_q         <= wr_n_d;
      a0_q           <= a0_d;
      data_out_q     <= data_out_d;
      data_oe_q      <= data_oe_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.inta_n       = inta_n_q;
  assign bus.wr_n         = wr_n_q;
  assign bus.a0           = a0_q;
  assign bus.data_out     = data_out_q;
  assign bus.data_oe      = data_oe_q;
  assign bus.vector_out   = vector_out_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inta_sequencer: directed table, corner sequences, random vs model |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_inta_sequencer;

  localparam int L0 = 2, G0 = 2, W0 = 2;
  localparam int L1 = 1, G1 = 3, W1 = 4;
  localparam int M_IDLE = 0, M_SEQ = 1, M_DEL = 2, M_WAIT = 3, M_EOI = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0, en = 1'b0, rdy = 1'b0, svc = 1'b0;
  logic [7:0] din = 8'h00;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  always #5 clk = ~clk;

  inta_sequencer_if bus0 ();
  inta_sequencer_if bus1 ();

  assign bus0.int_req = req;  assign bus1.int_req = req;
  assign bus0.int_enable = en; assign bus1.int_enable = en;
  assign bus0.data_in = din;  assign bus1.data_in = din;
  assign bus0.vec_ready = rdy; assign bus1.vec_ready = rdy;
  assign bus0.svc_done = svc; assign bus1.svc_done = svc;

  inta_sequencer #(.INTA_LOW_CYCLES(L0), .INTA_GAP_CYCLES(G0),
                   .WR_LOW_CYCLES(W0), .AUTO_EOI(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  inta_sequencer #(.INTA_LOW_CYCLES(L1), .INTA_GAP_CYCLES(G1),
                   .WR_LOW_CYCLES(W1), .AUTO_EOI(1'b1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [21:0] act0, act1;
  assign act0 = {bus0.inta_n, bus0.wr_n, bus0.a0, bus0.data_out, bus0.data_oe,
                 bus0.vector_out, bus0.vector_valid, bus0.busy};
  assign act1 = {bus1.inta_n, bus1.wr_n, bus1.a0, bus1.data_out, bus1.data_oe,
                 bus1.vector_out, bus1.vector_valid, bus1.busy};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", name, ecnt, act, exp);
    end
  endtask

  // Reference model: a timeline of offsets from the triggering edge.
  int         mode[2];
  int         t0[2];
  logic [7:0] mvec[2];
  bit         pend[2];

  function automatic int p_low(int k);  return (k == 0) ? L0 : L1; endfunction
  function automatic int p_gap(int k);  return (k == 0) ? G0 : G1; endfunction
  function automatic int p_wr(int k);   return (k == 0) ? W0 : W1; endfunction
  function automatic bit p_aeoi(int k); return (k == 1);           endfunction

  task automatic model_reset(int k);
    mode[k] = M_IDLE; t0[k] = 0; mvec[k] = 8'h00; pend[k] = 1'b0;
  endtask

  task automatic model_step(int k, int e);
    int d;
    d = e - t0[k];
    case (mode[k])
      M_IDLE: if (req && en) begin mode[k] = M_SEQ; t0[k] = e; end
      M_SEQ:  if (d == 2 * p_low(k) + p_gap(k) + 1) begin
                mvec[k] = din; mode[k] = M_DEL;
              end
      M_DEL:  if (rdy) begin mode[k] = M_WAIT; pend[k] = 1'b0; end
      M_WAIT: if (pend[k]) mode[k] = p_aeoi(k) ? M_IDLE : M_EOI;
              else if (svc) begin pend[k] = 1'b1; t0[k] = e; end
      M_EOI:  if (d == p_wr(k) + 2) mode[k] = M_IDLE;
      default: mode[k] = M_IDLE;
    endcase
  endtask

  function automatic logic [21:0] model_out(int k, int e);
    int   d, l, g, w;
    logic in_n, wr, oe, val, bsy;
    d = e - t0[k]; l = p_low(k); g = p_gap(k); w = p_wr(k);
    in_n = !(mode[k] == M_SEQ && ((d >= 1 && d <= l) || (d >= l + g + 1 && d <= 2 * l + g)));
    val  = (mode[k] == M_DEL);
    bsy  = !(mode[k] == M_IDLE || (mode[k] == M_SEQ && d == 0));
    wr   = !(mode[k] == M_EOI && d >= 1 && d <= w);
    oe   = (mode[k] == M_EOI && d >= 1 && d <= w + 1);
    return {in_n, wr, 1'b0, oe ? 8'h20 : 8'h00, oe, mvec[k], val, bsy};
  endfunction

  always @(posedge clk) begin
    #1;
    ecnt++;
    for (int k = 0; k < 2; k++) begin
      if (reset) model_reset(k);
      else       model_step(k, ecnt);
    end
    cmp("model_dut0", 32'(act0), 32'(model_out(0, ecnt)));
    cmp("model_dut1", 32'(act1), 32'(model_out(1, ecnt)));
  end

  typedef struct {
    logic        req, en;
    logic [7:0]  din;
    logic        rdy, svc;
    logic [21:0] exp0;
    logic [2:0]  exp1;   // dut1 {wr_n, vector_valid, busy}
  } vec_t;

  vec_t        tbl[45];
  logic [21:0] rst_out;
  logic [21:0] idle4b;

  initial begin
    rst_out = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    idle4b  = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h4B, 1'b0, 1'b0};

    // Table index i describes edge k=i+1 after reset release.
    for (int i = 0; i < 45; i++) begin
      int   k;
      logic oe;
      k = i + 1;
      oe = (k >= 41 && k <= 43);
      tbl[i].req  = (k >= 3 && k <= 12);
      tbl[i].en   = (k >= 10);
      tbl[i].din  = (k == 16 || k == 17) ? 8'h4B : 8'hC3;
      tbl[i].rdy  = (k == 23 || k == 30);
      tbl[i].svc  = (k == 5 || k == 20 || k == 40);
      tbl[i].exp0 = {!((k >= 11 && k <= 12) || (k >= 15 && k <= 16)),
                     !(k >= 41 && k <= 42), 1'b0, oe ? 8'h20 : 8'h00, oe,
                     (k >= 17) ? 8'h4B : 8'h00, (k >= 17 && k <= 22),
                     (k >= 11 && k <= 43)};
      tbl[i].exp1 = {1'b1, (k >= 16 && k <= 22), (k >= 11 && k <= 40)};
    end

    repeat (3) @(posedge clk);
    #1;
    cmp("reset_state_dut0", 32'(act0), 32'(rst_out));
    cmp("reset_state_dut1", 32'(act1), 32'(rst_out));
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      req = tbl[i].req; en = tbl[i].en; din = tbl[i].din;
      rdy = tbl[i].rdy; svc = tbl[i].svc;
      @(posedge clk);
      #1;
      cmp($sformatf("table_dut0_e%0d", i + 1), 32'(act0), 32'(tbl[i].exp0));
      cmp($sformatf("table_dut1_e%0d", i + 1), 32'({bus1.wr_n, bus1.vector_valid, bus1.busy}),
          32'(tbl[i].exp1));
    end

    // int_enable low must block a pending int_req.
    @(negedge clk);
    en = 1'b0; req = 1'b1; rdy = 1'b0; svc = 1'b0; din = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cmp("enable_gated", 32'(act0), 32'(idle4b));
    end
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1;
    cmp("enable_sample_edge", 32'({act0[21], act0[0]}), 32'(2'b10));
    @(posedge clk);
    #1;
    cmp("enable_inta1_start", 32'({act0[21], act0[0]}), 32'(2'b01));

    // Async reset in the middle of INTA2.
    repeat (4) @(posedge clk);
    #4;
    cmp("pre_reset_in_inta2", 32'({act0[21], act0[0]}), 32'(2'b01));
    reset = 1'b1;
    #1;
    cmp("reset_mid_inta2_dut0", 32'(act0), 32'(rst_out));
    cmp("reset_mid_dut1", 32'(act1), 32'(rst_out));
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    cmp("post_reset_sample", 32'({act0[21], act0[0]}), 32'(2'b10));
    @(posedge clk);
    #1;
    cmp("post_reset_restart", 32'({act0[21], act0[0]}), 32'(2'b01));

    // Randomized traffic, checked by the reference model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 7) != 0);
      din   = 8'($urandom);
      rdy   = ($urandom_range(0, 2) == 0);
      svc   = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    req = 1'b0; en = 1'b0; rdy = 1'b0; svc = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
